// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO that sits behind the uart
// receiver. It catches single-cycle received pulses so that a slow consumer
// drops nothing. It also keeps a sticky overflow flag and a saturating count
// of framing errors.
module uart_rx_fifo #(
  parameter int depth_log2 = 4,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [data_width-1:0] rx_byte,
  input  logic                  recv_error,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clear,
  output logic [data_width-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic [depth_log2:0]   count,
  output logic                  overflow,
  output logic [7:0]            err_count
);

  localparam int depth = 1 << depth_log2;
  // Count value at capacity: MSB set, rest zero.
  localparam logic [depth_log2:0] full_cnt = {1'b1, {depth_log2{1'b0}}};

  // A write request carries the byte together with its qualifier.
  typedef struct packed {
    logic                  vld;
    logic [data_width-1:0] data;
  } wr_req_t;

  logic [data_width-1:0] mem [depth];
  logic [depth_log2-1:0] wr_ptr, rd_ptr;
  logic [depth_log2:0]   count_q, count_d;
  logic                  overflow_q;
  logic [7:0]            err_q;

  wr_req_t wr_req;
  logic    pop, push, drop;

  // A byte that arrives flagged with a framing error is never stored.
  assign wr_req.vld  = received & ~recv_error;
  assign wr_req.data = rx_byte;

  assign valid = (count_q != '0);
  assign full  = (count_q == full_cnt);
  assign count = count_q;

  // A pop needs data. A push into a full FIFO is still accepted when the
  // same-cycle pop frees a slot. Flush discards both.
  assign pop  = rd_en & valid & ~flush;
  assign push = wr_req.vld & (~full | pop) & ~flush;
  // A drop is a real loss. A byte discarded by flush is not an overflow.
  assign drop = wr_req.vld & full & ~pop & ~flush;

  // Next count: unchanged on push+pop or on neither.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers. Flush takes priority over traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset: its contents are unused until a write occurs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_req.data;
  end

  // Sticky overflow. A drop in the same cycle as clear still sets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       overflow_q <= 1'b0;
    else if (drop)  overflow_q <= 1'b1;
    else if (clear) overflow_q <= 1'b0;
  end

  // Saturating framing-error count. An error during clear leaves it at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (recv_error) begin
      if (clear)              err_q <= 8'd1;
      else if (err_q != 8'hFF) err_q <= err_q + 8'd1;
    end else if (clear) begin
      err_q <= '0;
    end
  end

  assign overflow  = overflow_q;
  assign err_count = err_q;
  // dout shows the head entry directly and reads 0 while the FIFO is empty.
  assign dout = valid ? mem[rd_ptr] : '0;

endmodule
